// File: rtl/rtx_pkg.sv
// -----------------------------------------------------------------------------
// rtx_pkg
//   Shared types for the ray-tracing pipeline.
//   fp24 layout: [23] sign, [22:16] exponent (bias 63), [15:0] mantissa.
//   Provides vector/colour structs, the unit-white constant, the bounce
//   sequencer state encoding and a bitwise black-colour test.
// -----------------------------------------------------------------------------
package rtx_pkg;

  typedef logic [23:0] fp24;

  typedef struct packed {
    fp24 x;
    fp24 y;
    fp24 z;
  } fp24_vec3;

  typedef struct packed {
    fp24 r;
    fp24 g;
    fp24 b;
  } fp24_color;

  localparam fp24       FP24_ONE   = 24'h3F0000;
  localparam fp24_color FP24_WHITE = '{r: FP24_ONE, g: FP24_ONE, b: FP24_ONE};

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_HIT,
    WAIT_RFLX,
    DONE
  } bounce_state_t;

  // Pure bit test: no fp decode, so -0.0 is deliberately not treated as black.
  function automatic logic is_black(input fp24_color c);
    return (c.r == '0) && (c.g == '0) && (c.b == '0);
  endfunction

endpackage

// File: rtl/ray_bounce_ctrl_wd_timer.sv
// -----------------------------------------------------------------------------
// wd_timer
//   Watchdog counter for the bounce sequencer wait states.
//   Ports:
//     clk, rst_n  clock, async active-low reset
//     i_clear     zero the counter (wins over enable)
//     i_enable    count one cycle of waiting
//     o_expired   high in the cycle the counter sits at TIMEOUT_CYCLES-1
//                 while enabled; the owner aborts on that cycle
// -----------------------------------------------------------------------------
module wd_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign o_expired = i_enable && !i_clear && w_at_last;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !w_at_last) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ray_bounce_ctrl.sv
// -----------------------------------------------------------------------------
// ray_bounce_ctrl
//   Per-pixel path sequencer. Takes one primary ray, issues it to the
//   intersector, feeds reflector results back as the next ray, and stops on a
//   miss, after MAX_BOUNCES rays, on black throughput, or on watchdog timeout.
//   Ports:
//     pix_valid/pix_ready/pix_*      primary ray input (ready only in IDLE)
//     ray_valid/ray_*/income_light   current ray to intersector/reflector
//     hit_valid/hit_miss             intersector verdict
//     reflect_done/new_*             reflector result
//     out_valid/out_ready/out_*      per-pixel result
// -----------------------------------------------------------------------------
module ray_bounce_ctrl
  import rtx_pkg::*;
#(
  parameter int MAX_BOUNCES    = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int PIX_IDX_W      = 19
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pix_valid,
  output logic                               pix_ready,
  input  logic [PIX_IDX_W-1:0]               pix_idx,
  input  fp24_vec3                           pix_origin,
  input  fp24_vec3                           pix_dir,
  output logic                               ray_valid,
  output fp24_vec3                           ray_origin,
  output fp24_vec3                           ray_dir,
  output fp24_color                          ray_color,
  output fp24_color                          income_light,
  input  logic                               hit_valid,
  input  logic                               hit_miss,
  input  logic                               reflect_done,
  input  fp24_vec3                           new_origin,
  input  fp24_vec3                           new_dir,
  input  fp24_color                          new_color,
  input  fp24_color                          new_income_light,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [PIX_IDX_W-1:0]               out_idx,
  output fp24_color                          out_light,
  output logic [$clog2(MAX_BOUNCES+1)-1:0]   out_bounces,
  output logic                               out_timeout
);

  localparam int BCNT_W = $clog2(MAX_BOUNCES + 1);
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(MAX_BOUNCES);

  bounce_state_t r_state, w_next_state;

  logic                 r_pix_ready;
  logic [PIX_IDX_W-1:0] r_idx;
  fp24_vec3             r_ray_origin, r_ray_dir;
  fp24_color            r_ray_color, r_income_light;
  logic [BCNT_W-1:0]    r_bounce_cnt;

  logic                 r_out_valid;
  logic [PIX_IDX_W-1:0] r_out_idx;
  fp24_color            r_out_light;
  logic [BCNT_W-1:0]    r_out_bounces;
  logic                 r_out_timeout;

  logic      w_accept;
  logic      w_reflect;
  logic      w_finish;
  logic      w_abort;
  fp24_color w_final_light;
  logic      w_wd_clear;
  logic      w_wd_enable;
  logic      w_wd_expired;

  assign w_accept  = (r_state == IDLE) && pix_valid && r_pix_ready;
  assign w_reflect = (r_state == WAIT_RFLX) && reflect_done;

  // Counter restarts on every entry to WAIT_HIT (from ISSUE) and WAIT_RFLX.
  assign w_wd_clear  = (r_state == ISSUE) ||
                       ((r_state == WAIT_HIT) && hit_valid && !hit_miss);
  assign w_wd_enable = (r_state == WAIT_HIT) || (r_state == WAIT_RFLX);

  wd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_enable),
    .o_expired(w_wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every signal written here gets a default first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_finish     = 1'b0;
    w_abort      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = ISSUE;
      end
      ISSUE: begin
        w_next_state = WAIT_HIT;
      end
      WAIT_HIT: begin
        if (hit_miss) begin
          w_next_state = DONE;
          w_finish     = 1'b1;
        end else if (hit_valid) begin
          w_next_state = WAIT_RFLX;
        end else if (w_wd_expired) begin
          w_next_state = DONE;
          w_finish     = 1'b1;
          w_abort      = 1'b1;
        end
      end
      WAIT_RFLX: begin
        if (reflect_done) begin
          if ((r_bounce_cnt == BCNT_MAX) || is_black(new_color)) begin
            w_next_state = DONE;
            w_finish     = 1'b1;
          end else begin
            w_next_state = ISSUE;
          end
        end else if (w_wd_expired) begin
          w_next_state = DONE;
          w_finish     = 1'b1;
          w_abort      = 1'b1;
        end
      end
      DONE: begin
        if (r_out_valid && out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // A pixel finishing out of WAIT_RFLX reports the light the reflector just
  // produced, which only lands in r_income_light on this same edge.
  assign w_final_light = w_reflect ? new_income_light : r_income_light;

  // NOTE: the datapath registers are few and narrow, so all of them take the
  // async reset; this keeps post-reset outputs at a known zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_ready    <= 1'b0;
      r_idx          <= '0;
      r_ray_origin   <= '0;
      r_ray_dir      <= '0;
      r_ray_color    <= '0;
      r_income_light <= '0;
      r_bounce_cnt   <= '0;
    end else begin
      // Registered so pix_ready rises on the first edge after reset release.
      r_pix_ready <= (w_next_state == IDLE);
      if (w_accept) begin
        r_idx          <= pix_idx;
        r_ray_origin   <= pix_origin;
        r_ray_dir      <= pix_dir;
        r_ray_color    <= FP24_WHITE;
        r_income_light <= '0;
        r_bounce_cnt   <= '0;
      end
      if ((r_state == ISSUE) && (r_bounce_cnt != BCNT_MAX)) begin
        r_bounce_cnt <= r_bounce_cnt + BCNT_W'(1);
      end
      if (w_reflect) begin
        r_ray_origin   <= new_origin;
        r_ray_dir      <= new_dir;
        r_ray_color    <= new_color;
        r_income_light <= new_income_light;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_idx     <= '0;
      r_out_light   <= '0;
      r_out_bounces <= '0;
      r_out_timeout <= 1'b0;
    end else if (w_finish) begin
      r_out_valid   <= 1'b1;
      r_out_idx     <= r_idx;
      r_out_light   <= w_final_light;
      r_out_bounces <= r_bounce_cnt;
      r_out_timeout <= w_abort;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign pix_ready    = r_pix_ready;
  assign ray_valid    = (r_state == ISSUE);
  assign ray_origin   = r_ray_origin;
  assign ray_dir      = r_ray_dir;
  assign ray_color    = r_ray_color;
  assign income_light = r_income_light;
  assign out_valid    = r_out_valid;
  assign out_idx      = r_out_idx;
  assign out_light    = r_out_light;
  assign out_bounces  = r_out_bounces;
  assign out_timeout  = r_out_timeout;

endmodule

// File: tb/tb_ray_bounce_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ray_bounce_ctrl
//   Directed bench for ray_bounce_ctrl (MAX_BOUNCES=4, TIMEOUT_CYCLES=16).
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_ray_bounce_ctrl;
  import rtx_pkg::*;

  localparam int MAXB = 4;
  localparam int TMO  = 16;
  localparam int IDXW = 19;

  localparam logic [71:0] WHITE = 72'h3F0000_3F0000_3F0000;
  localparam logic [71:0] HALF  = 72'h3E0000_3E0000_3E0000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            pix_valid;
  logic            pix_ready;
  logic [IDXW-1:0] pix_idx;
  fp24_vec3        pix_origin, pix_dir;
  logic            ray_valid;
  fp24_vec3        ray_origin, ray_dir;
  fp24_color       ray_color, income_light;
  logic            hit_valid, hit_miss, reflect_done;
  fp24_vec3        new_origin, new_dir;
  fp24_color       new_color, new_income_light;
  logic            out_valid, out_ready;
  logic [IDXW-1:0] out_idx;
  fp24_color       out_light;
  logic [2:0]      out_bounces;
  logic            out_timeout;

  int n_vec  = 0;
  int n_err  = 0;
  int n_rays = 0;

  always #5 clk = ~clk;

  ray_bounce_ctrl #(
    .MAX_BOUNCES(MAXB), .TIMEOUT_CYCLES(TMO), .PIX_IDX_W(IDXW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_idx(pix_idx),
    .pix_origin(pix_origin), .pix_dir(pix_dir),
    .ray_valid(ray_valid), .ray_origin(ray_origin), .ray_dir(ray_dir),
    .ray_color(ray_color), .income_light(income_light),
    .hit_valid(hit_valid), .hit_miss(hit_miss), .reflect_done(reflect_done),
    .new_origin(new_origin), .new_dir(new_dir), .new_color(new_color),
    .new_income_light(new_income_light),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_light(out_light), .out_bounces(out_bounces), .out_timeout(out_timeout)
  );

  always @(negedge clk) if (ray_valid) n_rays <= n_rays + 1;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge where ray_valid is seen.
  task automatic wait_ray(input string tag);
    int i;
    for (i = 0; i < 40 && !ray_valid; i++) @(negedge clk);
    if (!ray_valid) check({tag, "_ray_wait"}, 0, 1);
  endtask

  // Returns number of falling edges waited until out_valid.
  task automatic wait_out(input string tag, output int waited);
    waited = 0;
    while (!out_valid && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) check({tag, "_out_wait"}, 0, 1);
  endtask

  // Offers a pixel; returns at the first falling edge after acceptance.
  task automatic send_pixel(input logic [IDXW-1:0] idx, input fp24_vec3 org, input fp24_vec3 dir);
    int i;
    pix_valid = 1'b1; pix_idx = idx; pix_origin = org; pix_dir = dir;
    for (i = 0; i < 40 && !pix_ready; i++) @(negedge clk);
    if (!pix_ready) check("pix_ready_wait", 0, 1);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic pop_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // From ISSUE falling edge: hit in WAIT_HIT, then reflector result.
  task automatic hit_reflect(input fp24_vec3 org, input fp24_color col, input fp24_color lt);
    @(negedge clk);
    hit_valid = 1'b1;
    @(negedge clk);
    hit_valid = 1'b0;
    reflect_done = 1'b1; new_origin = org; new_dir = org ^ 72'h1;
    new_color = col; new_income_light = lt;
    @(negedge clk);
    reflect_done = 1'b0;
  endtask

  initial begin
    int        w, r0;
    fp24_vec3  org;
    fp24_color lt;

    rst_n = 1'b0; pix_valid = 0; pix_idx = '0; pix_origin = '0; pix_dir = '0;
    hit_valid = 0; hit_miss = 0; reflect_done = 0; out_ready = 0;
    new_origin = '0; new_dir = '0; new_color = '0; new_income_light = '0;

    // Reset state
    #1;
    check("rst_pix_ready", pix_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_ray_valid", ray_valid, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_pix_ready", pix_ready, 1);

    // Immediate miss, idx=5
    org = '{x: 24'h000100, y: 24'h000200, z: 24'h000300};
    send_pixel(19'd5, org, '{x: 24'h3F0000, y: 24'h0, z: 24'h0});
    check("miss_ray_valid_lat1", ray_valid, 1);
    check("miss_ray_origin", ray_origin, org);
    check("miss_ray_color", ray_color, WHITE);
    check("miss_income0", income_light, 0);
    check("miss_pix_ready_busy", pix_ready, 0);
    repeat (3) @(negedge clk);
    hit_miss = 1'b1;
    @(negedge clk);
    hit_miss = 1'b0;
    check("miss_out_valid", out_valid, 1);
    check("miss_out_idx", out_idx, 5);
    check("miss_out_light", out_light, 0);
    check("miss_out_bounces", out_bounces, 1);
    check("miss_out_timeout", out_timeout, 0);
    pop_result();
    check("miss_out_valid_clr", out_valid, 0);
    check("miss_pix_ready_back", pix_ready, 1);

    // Max bounces: four rays, all hit, colour 0.5
    r0 = n_rays;
    send_pixel(19'd7, org, org);
    for (int k = 0; k < MAXB; k++) begin
      wait_ray("maxb");
      lt = '{r: 24'h3A0000 + 24'(k), g: 24'h3B0000 + 24'(k), b: 24'h3C0000 + 24'(k)};
      hit_reflect(org + 72'(k + 1), HALF, lt);
      if (k < MAXB - 1) begin
        check("maxb_next_ray_lat", ray_valid, 1);
        check("maxb_ray_color", ray_color, HALF);
        check("maxb_ray_origin", ray_origin, org + 72'(k + 1));
        check("maxb_income", income_light, lt);
      end
    end
    check("maxb_out_valid", out_valid, 1);
    check("maxb_out_bounces", out_bounces, 4);
    check("maxb_out_light", out_light, 72'h3A0003_3B0003_3C0003);
    repeat (3) @(negedge clk);
    check("maxb_ray_count", n_rays - r0, 4);
    pop_result();

    // Black throughput after first bounce
    r0 = n_rays;
    send_pixel(19'd9, org, org);
    hit_reflect(org, '0, '{r: 24'h123456, g: 24'h0, b: 24'h0});
    check("black_out_valid", out_valid, 1);
    check("black_out_bounces", out_bounces, 1);
    check("black_out_light", out_light, 72'h123456_000000_000000);

    // Backpressure on the pending black result
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_idx", out_idx, 9);
      check("bp_pix_ready", pix_ready, 0);
    end
    check("black_ray_count", n_rays - r0, 1);
    pop_result();
    check("bp_release_pix_ready", pix_ready, 1);
    check("bp_release_out_valid", out_valid, 0);

    // Watchdog in WAIT_HIT: out_valid 16 cycles after WAIT_HIT entry
    send_pixel(19'd11, org, org);
    wait_out("tmo_hit", w);
    check("tmo_hit_latency", w, TMO + 1);
    check("tmo_hit_flag", out_timeout, 1);
    check("tmo_hit_bounces", out_bounces, 1);
    check("tmo_hit_idx", out_idx, 11);
    pop_result();

    // Watchdog in WAIT_RFLX: counter restarts on WAIT_RFLX entry
    send_pixel(19'd12, org, org);
    @(negedge clk);
    repeat (4) @(negedge clk);
    hit_valid = 1'b1;
    @(negedge clk);
    hit_valid = 1'b0;
    wait_out("tmo_rflx", w);
    check("tmo_rflx_latency", w, TMO);
    check("tmo_rflx_flag", out_timeout, 1);
    pop_result();

    // Simultaneous hit and miss: miss wins; stray reflect_done in DONE ignored
    send_pixel(19'd13, org, org);
    @(negedge clk);
    hit_valid = 1'b1; hit_miss = 1'b1;
    @(negedge clk);
    hit_valid = 1'b0; hit_miss = 1'b0;
    check("both_out_valid", out_valid, 1);
    check("both_out_timeout", out_timeout, 0);
    check("both_out_bounces", out_bounces, 1);
    reflect_done = 1'b1; new_color = HALF; new_income_light = HALF;
    @(negedge clk);
    reflect_done = 1'b0;
    check("both_stray_light", out_light, 0);
    check("both_stray_color", ray_color, WHITE);
    pop_result();

    // Async reset in WAIT_RFLX
    send_pixel(19'd14, org, org);
    @(negedge clk);
    hit_valid = 1'b1;
    @(negedge clk);
    hit_valid = 1'b0;
    r0 = n_rays;
    #2 rst_n = 1'b0;
    #1;
    check("arst_ray_origin", ray_origin, 0);
    check("arst_ray_color", ray_color, 0);
    check("arst_pix_ready", pix_ready, 0);
    check("arst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    reflect_done = 1'b1; new_color = HALF; new_income_light = HALF; new_origin = org;
    @(negedge clk);
    reflect_done = 1'b0;
    check("arst_ignored_color", ray_color, 0);
    check("arst_ignored_light", income_light, 0);
    check("arst_pix_ready_back", pix_ready, 1);
    repeat (2) @(negedge clk);
    check("arst_no_ray", n_rays - r0, 0);
    check("arst_no_out", out_valid, 0);

    // Next pixel after reset behaves normally
    send_pixel(19'd3, org, org);
    check("post_arst_ray_color", ray_color, WHITE);
    @(negedge clk);
    hit_miss = 1'b1;
    @(negedge clk);
    hit_miss = 1'b0;
    check("post_arst_out_idx", out_idx, 3);
    check("post_arst_bounces", out_bounces, 1);
    pop_result();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: bench did not complete");
    $fatal(1);
  end

endmodule
